// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles command frames from the UART byte stream.
// Frame: HEADER, CMD, ADDR, DATA_H, DATA_L [, CHK].
// Define UART_CMD_PARSER_CHECKSUM_EN to append the XOR checksum byte (CHK) and enable ERR_CHK.
// Without the macro the frame is five bytes long and ERR_CHK is tied low.
// Inter-byte timeout and good-frame counter are always present.
module uart_cmd_parser #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 8680
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic [7:0]  DATA_IN,
    input  logic        VALID_IN,
    output logic [7:0]  CMD,
    output logic [7:0]  ADDR,
    output logic [15:0] WDATA,
    output logic        CMD_VALID,
    output logic        ERR_CHK,
    output logic        ERR_TO,
    output logic [15:0] FRAME_CNT
);

    // Last counter value before a missing byte counts as a timeout.
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DH   = 3'd3,
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        S_DL   = 3'd4,
        S_CHK  = 3'd5
`else
        S_DL   = 3'd4
`endif
    } state_e;

`ifdef UART_CMD_PARSER_CHECKSUM_EN
    // Running checksum: XOR of every payload byte.
    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_e      state_q, state_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [7:0]  cmd_sh_q, cmd_sh_d;
    logic [7:0]  addr_sh_q, addr_sh_d;
    logic [7:0]  dh_sh_q, dh_sh_d;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
    logic [7:0]  dl_sh_q, dl_sh_d;
    logic [7:0]  xor_q, xor_d;
    logic        err_chk_d;
`endif
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        err_chk_q;
    logic        err_to_q, err_to_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        timeout_hit_s;

    // A timeout fires only when the limit is reached in a frame with no byte arriving.
    assign timeout_hit_s = (state_q != IDLE) && !VALID_IN && (to_cnt_q == TO_LIMIT);

    // State register.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: advance on each strobe, fall back to IDLE on timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (VALID_IN && (DATA_IN == HEADER)) begin
                    state_d = S_CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            S_CMD: begin
                if (VALID_IN) begin
                    state_d = S_ADDR;
                end else if (timeout_hit_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = S_CMD;
                end
            end
            S_ADDR: begin
                if (VALID_IN) begin
                    state_d = S_DH;
                end else if (timeout_hit_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DH: begin
                if (VALID_IN) begin
                    state_d = S_DL;
                end else if (timeout_hit_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = S_DH;
                end
            end
            S_DL: begin
                if (VALID_IN) begin
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = IDLE;
`endif
                end else if (timeout_hit_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = S_DL;
                end
            end
`ifdef UART_CMD_PARSER_CHECKSUM_EN
            S_CHK: begin
                if (VALID_IN || timeout_hit_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = S_CHK;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: shadow capture, checksum, result load, pulses, timeout counter.
    always_comb begin
        cmd_sh_d    = cmd_sh_q;
        addr_sh_d   = addr_sh_q;
        dh_sh_d     = dh_sh_q;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        dl_sh_d     = dl_sh_q;
        xor_d       = xor_q;
        err_chk_d   = 1'b0;
`endif
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        frame_cnt_d = frame_cnt_q;
        cmd_valid_d = 1'b0;
        err_to_d    = 1'b0;

        // Counter runs only inside a frame and restarts on every accepted byte.
        if ((state_q == IDLE) || VALID_IN || timeout_hit_s) begin
            to_cnt_d = 32'd0;
        end else begin
            to_cnt_d = to_cnt_q + 32'd1;
        end

        if (timeout_hit_s) begin
            err_to_d  = 1'b1;
            cmd_sh_d  = 8'h00;
            addr_sh_d = 8'h00;
            dh_sh_d   = 8'h00;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
            dl_sh_d   = 8'h00;
            xor_d     = 8'h00;
`endif
        end else if (VALID_IN) begin
            case (state_q)
                S_CMD: begin
                    cmd_sh_d = DATA_IN;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                    xor_d    = chk_update(8'h00, DATA_IN);
`endif
                end
                S_ADDR: begin
                    addr_sh_d = DATA_IN;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                    xor_d     = chk_update(xor_q, DATA_IN);
`endif
                end
                S_DH: begin
                    dh_sh_d = DATA_IN;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                    xor_d   = chk_update(xor_q, DATA_IN);
`endif
                end
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                S_DL: begin
                    dl_sh_d = DATA_IN;
                    xor_d   = chk_update(xor_q, DATA_IN);
                end
                S_CHK: begin
                    if (DATA_IN == xor_q) begin
                        cmd_d       = cmd_sh_q;
                        addr_d      = addr_sh_q;
                        wdata_d     = {dh_sh_q, dl_sh_q};
                        cmd_valid_d = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        err_chk_d = 1'b1;
                    end
                end
`else
                S_DL: begin
                    cmd_d       = cmd_sh_q;
                    addr_d      = addr_sh_q;
                    wdata_d     = {dh_sh_q, DATA_IN};
                    cmd_valid_d = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
`endif
                default: begin
                    cmd_sh_d = cmd_sh_q;
                end
            endcase
        end else begin
            cmd_sh_d = cmd_sh_q;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            to_cnt_q    <= 32'd0;
            cmd_sh_q    <= 8'h00;
            addr_sh_q   <= 8'h00;
            dh_sh_q     <= 8'h00;
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            wdata_q     <= 16'h0000;
            cmd_valid_q <= 1'b0;
            err_to_q    <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            to_cnt_q    <= to_cnt_d;
            cmd_sh_q    <= cmd_sh_d;
            addr_sh_q   <= addr_sh_d;
            dh_sh_q     <= dh_sh_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_valid_q <= cmd_valid_d;
            err_to_q    <= err_to_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef UART_CMD_PARSER_CHECKSUM_EN
    // Checksum-only state: last data byte, running XOR and the mismatch pulse.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            dl_sh_q   <= 8'h00;
            xor_q     <= 8'h00;
            err_chk_q <= 1'b0;
        end else begin
            dl_sh_q   <= dl_sh_d;
            xor_q     <= xor_d;
            err_chk_q <= err_chk_d;
        end
    end
`else
    assign err_chk_q = 1'b0;
`endif

    assign CMD       = cmd_q;
    assign ADDR      = addr_q;
    assign WDATA     = wdata_q;
    assign CMD_VALID = cmd_valid_q;
    assign ERR_CHK   = err_chk_q;
    assign ERR_TO    = err_to_q;
    assign FRAME_CNT = frame_cnt_q;

endmodule
